// File: rtl/test_controller_if.sv
// Host-side bundle for test_controller: run request, check table, processor
// observation inputs and status/result outputs.
interface test_controller_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned NUM_CHECKS = 2,
  parameter int unsigned CNT_W      = 16
) ();
  logic                         start;
  logic [NUM_CHECKS*ADDR_W-1:0] exp_addr;
  logic [NUM_CHECKS*DATA_W-1:0] exp_data;
  logic [NUM_CHECKS-1:0]        check_en;
  logic [DATA_W-1:0]            pc;
  logic [DATA_W-1:0]            rf_data;
  logic                         cpu_rst;
  logic                         cpu_en;
  logic [ADDR_W-1:0]            rf_addr;
  logic                         busy;
  logic                         done;
  logic                         pass;
  logic                         halted;
  logic [NUM_CHECKS-1:0]        fail_mask;
  logic [CNT_W-1:0]             cycles;

  // Controller side.
  modport master (
    input  start, exp_addr, exp_data, check_en, pc, rf_data,
    output cpu_rst, cpu_en, rf_addr, busy, done, pass, halted, fail_mask, cycles
  );

  // Host / processor side.
  modport slave (
    output start, exp_addr, exp_data, check_en, pc, rf_data,
    input  cpu_rst, cpu_en, rf_addr, busy, done, pass, halted, fail_mask, cycles
  );
endinterface

// File: rtl/test_controller.sv
// Processor test sequencer: holds the core in reset, lets it run for a bounded
// number of cycles (or until the PC stalls), then reads back registers through
// the debug port and compares them against expected values.
module test_controller #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned NUM_CHECKS  = 2,
  parameter int unsigned RUN_CYCLES  = 50,
  parameter int unsigned RST_CYCLES  = 1,
  parameter int unsigned HALT_WINDOW = 4,
  parameter int unsigned CNT_W       = 16
) (
  input logic              clk,
  input logic              rst,
  test_controller_if.master bus
);

  localparam int unsigned RstCntW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned RunCntW  = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam int unsigned HaltCntW = (HALT_WINDOW > 0) ? $clog2(HALT_WINDOW + 1) : 1;
  localparam int unsigned IdxW     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  typedef enum logic [2:0] {StIdle, StReset, StRun, StCheck, StDone} state_e;

  state_e                state_q;
  logic [RstCntW-1:0]    rst_cnt_q;
  logic [RunCntW-1:0]    run_cnt_q;
  logic [HaltCntW-1:0]   hcnt_q;
  logic [DATA_W-1:0]     prev_pc_q;
  logic [IdxW-1:0]       idx_q;
  logic                  cpu_rst_q, cpu_en_q, busy_q, done_q, pass_q, halted_q;
  logic [NUM_CHECKS-1:0] fail_q;
  logic [CNT_W-1:0]      cycles_q;

  logic [HaltCntW-1:0]   hcnt_nxt;
  logic                  halt_hit;
  logic [NUM_CHECKS-1:0] fail_upd;

  // Stable-PC run length; the first RUN cycle has no valid previous PC.
  always_comb begin
    hcnt_nxt = '0;
    if (HALT_WINDOW != 0 && run_cnt_q != '0 && bus.pc == prev_pc_q) begin
      hcnt_nxt = hcnt_q + 1'b1;
    end
    halt_hit = (HALT_WINDOW != 0) && (hcnt_nxt == HaltCntW'(HALT_WINDOW));
  end

  // Fail mask including the comparison for the check being performed this cycle.
  always_comb begin
    fail_upd = fail_q;
    if (state_q == StCheck && bus.check_en[idx_q] &&
        bus.rf_data != bus.exp_data[idx_q*DATA_W +: DATA_W]) begin
      fail_upd[idx_q] = 1'b1;
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rst_cnt_q <= '0;
      run_cnt_q <= '0;
      hcnt_q    <= '0;
      prev_pc_q <= '0;
      idx_q     <= '0;
      cpu_rst_q <= 1'b1;
      cpu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      halted_q  <= 1'b0;
      fail_q    <= '0;
      cycles_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q   <= StReset;
            rst_cnt_q <= '0;
            run_cnt_q <= '0;
            hcnt_q    <= '0;
            idx_q     <= '0;
            cpu_rst_q <= 1'b1;
            cpu_en_q  <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            halted_q  <= 1'b0;
            fail_q    <= '0;
            cycles_q  <= '0;
          end
        end
        StReset: begin
          if (rst_cnt_q == RstCntW'(RST_CYCLES - 1)) begin
            state_q   <= StRun;
            cpu_rst_q <= 1'b0;
            cpu_en_q  <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        StRun: begin
          cycles_q  <= (&cycles_q) ? cycles_q : cycles_q + 1'b1;
          prev_pc_q <= bus.pc;
          run_cnt_q <= run_cnt_q + 1'b1;
          hcnt_q    <= hcnt_nxt;
          if (halt_hit || run_cnt_q == RunCntW'(RUN_CYCLES - 1)) begin
            state_q  <= StCheck;
            cpu_en_q <= 1'b0;
            halted_q <= halt_hit;
          end
        end
        StCheck: begin
          fail_q <= fail_upd;
          if (idx_q == IdxW'(NUM_CHECKS - 1)) begin
            state_q <= StDone;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_upd == '0);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rf_addr   = (state_q == StCheck) ? bus.exp_addr[idx_q*ADDR_W +: ADDR_W] : '0;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.cpu_en    = cpu_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.halted    = halted_q;
  assign bus.fail_mask = fail_q;
  assign bus.cycles    = cycles_q;

endmodule

// File: tb/tb_test_controller.sv
// Bench for test_controller: directed scenarios plus randomized runs checked
// against a window-based model of run length and per-check register compare.
module tb_test_controller;
  localparam int DW = 32, AW = 4, NC = 2, RUN = 50, RST = 1, HW = 4, CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  test_controller_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CHECKS(NC), .CNT_W(CW)) bus ();

  test_controller #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_CHECKS(NC), .RUN_CYCLES(RUN),
    .RST_CYCLES(RST), .HALT_WINDOW(HW), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] rf_mem [16];
  logic [DW-1:0] pcs [0:RUN];
  assign bus.rf_data = rf_mem[bus.rf_addr];

  int total = 0;
  int bad   = 0;

  // Run length: first RUN cycle j whose trailing HW+1 PCs (all within the run) are equal.
  function automatic void model_run(output int cyc, output bit hlt);
    bit same;
    cyc = RUN;
    hlt = 1'b0;
    for (int j = HW + 1; j <= RUN; j++) begin
      same = 1'b1;
      for (int k = j - HW + 1; k <= j; k++) if (pcs[k] != pcs[j-HW]) same = 1'b0;
      if (same) begin
        cyc = j;
        hlt = 1'b1;
        return;
      end
    end
  endfunction

  function automatic logic [NC-1:0] model_fail();
    logic [NC-1:0] m = '0;
    logic [AW-1:0] a;
    for (int i = 0; i < NC; i++) begin
      a = bus.exp_addr[i*AW +: AW];
      if (bus.check_en[i] && rf_mem[a] != bus.exp_data[i*DW +: DW]) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Starts a run at cycle 0, drives pcs[] into RUN cycles, optionally pulses start
  // at cycle poke, and returns done cycle, cpu_en-high count and cpu_en fall cycle.
  task automatic drive_run(input int poke, output int dc, output int ec, output int ef);
    int c, j;
    logic prev_en;
    dc = -1; ec = 0; ef = -1; prev_en = 1'b0;
    bus.start = 1'b1;
    bus.pc = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 1;
    while (dc < 0 && c < RUN + RST + NC + 20) begin
      bus.start = (c == poke);
      j = c - RST;
      bus.pc = (j >= 1 && j <= RUN) ? pcs[j] : '0;
      if (bus.cpu_en) ec++;
      if (prev_en && !bus.cpu_en && ef < 0) ef = c;
      prev_en = bus.cpu_en;
      if (bus.done) dc = c;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    flags = {bus.cpu_rst, bus.cpu_en, bus.busy, bus.done, bus.pass, bus.halted, 1'b0};
    total++; if (flags !== 7'b1000000) begin bad++; $display("FAIL reset_flags got %b want 1000000", flags); end
    total++; if (bus.fail_mask !== 2'b00) begin bad++; $display("FAIL reset_fail got %b want 00", bus.fail_mask); end
    total++; if (bus.cycles !== 16'd0) begin bad++; $display("FAIL reset_cycles got %0d want 0", bus.cycles); end
    total++; if (bus.rf_addr !== 4'd0) begin bad++; $display("FAIL reset_rf_addr got %0d want 0", bus.rf_addr); end
  endtask

  task automatic test_pass();
    int dc, ec, ef;
    for (int j = 1; j <= RUN; j++) pcs[j] = DW'(4 * j);
    rf_mem[8] = 32'd11;
    bus.exp_addr = {4'd3, 4'd8};
    bus.exp_data = {32'hdead_beef, 32'd11};
    bus.check_en = 2'b01;
    drive_run(20, dc, ec, ef);
    total++; if (dc !== 54) begin bad++; $display("FAIL pass_done_cycle got %0d want 54", dc); end
    total++; if (bus.pass !== 1'b1) begin bad++; $display("FAIL pass_pass got %b want 1", bus.pass); end
    total++; if (bus.cycles !== 16'd50) begin bad++; $display("FAIL pass_cycles got %0d want 50", bus.cycles); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL pass_halted got %b want 0", bus.halted); end
    total++; if (bus.fail_mask !== 2'b00) begin bad++; $display("FAIL pass_fail got %b want 00", bus.fail_mask); end
    total++; if (ec !== 50) begin bad++; $display("FAIL pass_en_count got %0d want 50", ec); end
    total++; if (ef !== 52) begin bad++; $display("FAIL pass_en_fall got %0d want 52", ef); end
    repeat (3) @(posedge clk); #1;
    total++; if ({bus.done, bus.pass, bus.busy, bus.cpu_en} !== 4'b1100) begin
      bad++; $display("FAIL pass_hold got %b want 1100", {bus.done, bus.pass, bus.busy, bus.cpu_en});
    end
  endtask

  task automatic test_mismatch();
    int dc, ec, ef;
    rf_mem[8] = 32'd1;
    drive_run(-1, dc, ec, ef);
    total++; if (dc !== 54) begin bad++; $display("FAIL mism_done_cycle got %0d want 54", dc); end
    total++; if (bus.fail_mask !== 2'b01) begin bad++; $display("FAIL mism_fail got %b want 01", bus.fail_mask); end
    total++; if (bus.pass !== 1'b0) begin bad++; $display("FAIL mism_pass got %b want 0", bus.pass); end
  endtask

  task automatic test_halt();
    int dc, ec, ef;
    for (int j = 1; j <= RUN; j++) pcs[j] = (j < 10) ? DW'(4 * j) : 32'h40;
    rf_mem[8] = 32'd11;
    drive_run(-1, dc, ec, ef);
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_flag got %b want 1", bus.halted); end
    total++; if (bus.cycles !== 16'd14) begin bad++; $display("FAIL halt_cycles got %0d want 14", bus.cycles); end
    total++; if (ec !== 14) begin bad++; $display("FAIL halt_en_count got %0d want 14", ec); end
    total++; if (ef !== 16) begin bad++; $display("FAIL halt_en_fall got %0d want 16", ef); end
    total++; if (dc !== 18) begin bad++; $display("FAIL halt_done_cycle got %0d want 18", dc); end
    total++; if (bus.pass !== 1'b1) begin bad++; $display("FAIL halt_pass got %b want 1", bus.pass); end
  endtask

  task automatic test_mask();
    int dc, ec, ef;
    for (int j = 1; j <= RUN; j++) pcs[j] = DW'(4 * j);
    rf_mem[8] = 32'd11;
    rf_mem[3] = 32'd5;
    bus.exp_addr = {4'd3, 4'd8};
    bus.exp_data = {32'd6, 32'd12};
    bus.check_en = 2'b10;
    drive_run(-1, dc, ec, ef);
    total++; if (bus.fail_mask !== 2'b10) begin bad++; $display("FAIL mask_fail got %b want 10", bus.fail_mask); end
    total++; if (dc !== 54) begin bad++; $display("FAIL mask_done_cycle got %0d want 54", dc); end
  endtask

  task automatic test_restart();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if ({bus.done, bus.busy, bus.cpu_rst, bus.cpu_en} !== 4'b0110) begin
      bad++; $display("FAIL restart_flags got %b want 0110", {bus.done, bus.busy, bus.cpu_rst, bus.cpu_en});
    end
    total++; if (bus.fail_mask !== 2'b00) begin bad++; $display("FAIL restart_fail got %b want 00", bus.fail_mask); end
    total++; if (bus.cycles !== 16'd0) begin bad++; $display("FAIL restart_cycles got %0d want 0", bus.cycles); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    for (int j = 1; j <= RUN; j++) pcs[j] = DW'(4 * j);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < RST + 20; c++) begin
      bus.pc = (c > RST) ? pcs[c-RST] : '0;
      @(posedge clk); #1;
    end
    // Now in RUN cycle 20: 19 RUN cycles completed.
    total++; if ({bus.cpu_en, bus.busy} !== 2'b11 || bus.cycles !== 16'd19) begin
      bad++; $display("FAIL midrun_state got en/busy=%b cycles=%0d want 11 19", {bus.cpu_en, bus.busy}, bus.cycles);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({bus.cpu_rst, bus.cpu_en, bus.busy, bus.halted} !== 4'b1000) begin
      bad++; $display("FAIL midrun_reset got %b want 1000", {bus.cpu_rst, bus.cpu_en, bus.busy, bus.halted});
    end
    total++; if (bus.cycles !== 16'd0) begin bad++; $display("FAIL midrun_cycles got %0d want 0", bus.cycles); end
  endtask

  task automatic test_rst_priority();
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    total++; if ({bus.busy, bus.cpu_rst, bus.done} !== 3'b010) begin
      bad++; $display("FAIL rst_priority got %b want 010", {bus.busy, bus.cpu_rst, bus.done});
    end
  endtask

  task automatic test_random();
    int dc, ec, ef, cyc, poke;
    bit hlt;
    logic [NC-1:0] ef_mask;
    for (int n = 0; n < 25; n++) begin
      pcs[1] = $urandom & 32'h0fff_fffc;
      for (int j = 2; j <= RUN; j++) pcs[j] = ($urandom_range(0, 2) == 0) ? pcs[j-1] : pcs[j-1] + 4;
      for (int a = 0; a < 16; a++) rf_mem[a] = $urandom_range(0, 7);
      for (int i = 0; i < NC; i++) begin
        bus.exp_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
        bus.exp_data[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? rf_mem[bus.exp_addr[i*AW +: AW]]
                                                              : DW'($urandom_range(0, 7));
      end
      bus.check_en = NC'($urandom_range(0, 3));
      model_run(cyc, hlt);
      ef_mask = model_fail();
      poke = $urandom_range(1, RST + cyc + NC);
      drive_run(poke, dc, ec, ef);
      total++; if (dc !== RST + cyc + NC + 1) begin
        bad++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", n, dc, RST + cyc + NC + 1);
      end
      total++; if (bus.cycles !== CW'(cyc) || bus.halted !== hlt) begin
        bad++; $display("FAIL rnd%0d_run got cycles=%0d halted=%b want %0d %b", n, bus.cycles, bus.halted, cyc, hlt);
      end
      total++; if (ec !== cyc || ef !== RST + cyc + 1) begin
        bad++; $display("FAIL rnd%0d_en got cnt=%0d fall=%0d want %0d %0d", n, ec, ef, cyc, RST + cyc + 1);
      end
      total++; if (bus.fail_mask !== ef_mask || bus.pass !== (ef_mask == '0)) begin
        bad++; $display("FAIL rnd%0d_result got fail=%b pass=%b want %b %b", n, bus.fail_mask, bus.pass,
                        ef_mask, (ef_mask == '0));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pc = '0;
    bus.exp_addr = '0;
    bus.exp_data = '0;
    bus.check_en = '0;
    for (int a = 0; a < 16; a++) rf_mem[a] = '0;
    for (int j = 0; j <= RUN; j++) pcs[j] = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_pass();
    test_mismatch();
    test_halt();
    test_mask();
    test_restart();
    test_reset_mid_run();
    test_rst_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/test_controller.md
TEST_CONTROLLER -- requirements
Module: test_controller

Interface
REQ-001 Parameter DATA_W, 32, processor data and PC width.
REQ-002 Parameter ADDR_W, 4, register-file index width.
REQ-003 Parameter NUM_CHECKS, 2, number of register checks; must be at least 1.
REQ-004 Parameter RUN_CYCLES, 50, maximum processor run cycles.
REQ-005 Parameter RST_CYCLES, 1, cycles of processor reset per run; must be at least 1.
REQ-006 Parameter HALT_WINDOW, 4, consecutive stable-PC cycles that mean halted; 0 disables halt detection.
REQ-007 Parameter CNT_W, 16, width of the cycles output.
REQ-008 clk  in  1  system clock; all state changes on its rising edge.
REQ-009 rst  in  1  reset; synchronous, active-high.
REQ-010 start  in  1  single-cycle request to begin a run.
REQ-011 exp_addr  in  NUM_CHECKS*ADDR_W  packed register indices; check i uses slice i.
REQ-012 exp_data  in  NUM_CHECKS*DATA_W  packed expected register values.
REQ-013 check_en  in  NUM_CHECKS  per-check enable mask.
REQ-014 pc  in  DATA_W  processor PC, used for halt detection.
REQ-015 rf_data  in  DATA_W  combinational register-file debug read data for rf_addr.
REQ-016 cpu_rst  out  1  processor reset.
REQ-017 cpu_en  out  1  processor clock enable.
REQ-018 rf_addr  out  ADDR_W  register-file debug read address.
REQ-019 busy, done, pass, halted  out  1 each  status flags.
REQ-020 fail_mask  out  NUM_CHECKS  one bit per failed check.
REQ-021 cycles  out  CNT_W  number of RUN cycles executed.

Function
REQ-022 FSM states SHALL be IDLE, RESET, RUN, CHECK and DONE.
REQ-023 IDLE: cpu_rst=1, cpu_en=0; start=1 moves to RESET and clears fail_mask, halted, cycles, pass and done.
REQ-024 RESET: cpu_rst=1, cpu_en=0 for exactly RST_CYCLES cycles, then RUN.
REQ-025 RUN: cpu_rst=0, cpu_en=1; cycles increments each RUN cycle and saturates at 2^CNT_W-1.
REQ-026 RUN exit: leave after the RUN_CYCLES-th RUN cycle, or earlier on halt; next state is CHECK.
REQ-027 Halt counter: previous PC is registered each RUN cycle.
- Counter increments when pc equals the previous PC and clears otherwise.
- The first RUN cycle never counts.
- When the counter reaches HALT_WINDOW (HALT_WINDOW>0), that cycle is the last RUN cycle and halted is set to 1.
REQ-028 CHECK: cpu_rst=0, cpu_en=0 (processor frozen); exactly NUM_CHECKS cycles, index i=0..NUM_CHECKS-1 in order.
- rf_addr is exp_addr slice i.
- If check_en[i]=1 and rf_data differs from exp_data slice i, fail_mask[i] is set.
- Disabled checks still take one cycle.
REQ-029 rf_addr SHALL be 0 outside CHECK.
REQ-030 DONE: cpu_rst=0, cpu_en=0, done=1, pass=(fail_mask==0); results hold until start or rst.
REQ-031 start in DONE behaves as start in IDLE.
REQ-032 busy=1 in RESET, RUN and CHECK; start while busy is ignored.
REQ-033 Latency: with start at cycle 0 and no halt, done rises at cycle 1+RST_CYCLES+RUN_CYCLES+NUM_CHECKS.

Reset
REQ-034 rst=1 SHALL, on the next edge, from any state (including mid-RUN or mid-CHECK), force IDLE.
- cpu_rst=1; cpu_en=0; busy=0; done=0; pass=0; halted=0.
- fail_mask=0; cycles=0; rf_addr=0.
- Halt counter, previous PC and check index cleared.
REQ-035 rst SHALL take priority over start in the same cycle.

Verification
REQ-036 Pass run: defaults, pc increments by 4 each cycle, rf_data=11 for addr 8, exp slice 0 = (8,11), check_en=01, start at cycle 0 -> done=1 at cycle 54, pass=1, cycles=50, halted=0.
REQ-037 Mismatch: same as REQ-036 but rf_data=1 for addr 8 -> fail_mask=01, pass=0, done=1 at cycle 54.
REQ-038 Halt: pc=0x40 constant from RUN cycle 10 onward -> halted=1, cycles=14, CHECK follows immediately, cpu_en=0 from the next cycle.
REQ-039 Mask: both checks mismatching, check_en=10 -> fail_mask=10; CHECK still lasts 2 cycles.
REQ-040 Reset mid-RUN: rst=1 at RUN cycle 20 -> next cycle IDLE, cpu_rst=1, cpu_en=0, busy=0, cycles=0.
REQ-041 Start handling: start pulsed during RUN is ignored (cycles unaffected); start in DONE clears done, fail_mask and cycles and re-enters RESET next cycle.
